// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Register file geometry and FSM state encoding.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational grant logic: one-hot grant plus index of the winner.
// Optional macro REGFILE_ARB_FIXED_PRIO_EN selects lowest-index priority.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

`ifdef REGFILE_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Lowest-index valid requester wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && valid[k]) begin
                grant[k] = 1'b1;
                idx      = PTR_W'(k);
                any      = 1'b1;
            end
        end
    end
`else
    // First valid requester at or after ptr, searching modulo N.
    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && valid[j]) begin
                grant[j] = 1'b1;
                idx      = PTR_W'(j);
                any      = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Clears x1..x31 after reset, then arbitrates writeback requests onto WE3/A3/WD3.
// Optional macro REGFILE_ARB_FIXED_PRIO_EN: fixed priority instead of round-robin.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*XLEN-1:0]    req_data,
    output logic                       rf_we,
    output logic [REG_ADDR_W-1:0]      rf_addr,
    output logic [XLEN-1:0]            rf_wdata,
    output logic                       init_done,
    output logic [CNT_W-1:0]           contention_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t                  state;
    state_t                  state_nxt;
    logic [REG_ADDR_W-1:0]   clr_cnt;
    logic [PTR_W-1:0]        ptr;
    logic [NUM_REQ-1:0]      grant;
    logic [PTR_W-1:0]        gidx;
    logic                    gany;
    logic                    multi;
    logic                    xfer;
    logic [REG_ADDR_W-1:0]   sel_addr;
    logic [XLEN-1:0]         sel_data;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [PTR_W-1:0] rr_ptr;
    assign ptr = rr_ptr;
`endif

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    assign init_done = (state == ST_RUN);
    assign req_ready = (init_done && !rst) ? grant : '0;
    assign xfer      = init_done && gany;
    assign sel_addr  = req_addr[REG_ADDR_W*gidx +: REG_ADDR_W];
    assign sel_data  = req_data[XLEN*gidx +: XLEN];

    // Two or more simultaneous requests count as contention.
    always_comb begin
        int n;
        n = 0;
        for (int k = 0; k < NUM_REQ; k++) n = n + int'(req_valid[k]);
        multi = (n >= 2);
    end

    // Next state: leave CLEAR after the x31 write is issued.
    always_comb begin
        state_nxt = state;
        if (state == ST_CLEAR && clr_cnt == REG_ADDR_W'(NUM_REGS - 1))
            state_nxt = ST_RUN;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_CLEAR;
        else     state <= state_nxt;
    end

    // Write-port registers and clear counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_addr  <= '0;
            rf_wdata <= '0;
            clr_cnt  <= REG_ADDR_W'(1);
        end else if (state == ST_CLEAR) begin
            rf_we    <= 1'b1;
            rf_addr  <= clr_cnt;
            rf_wdata <= '0;
            clr_cnt  <= clr_cnt + 1'b1;
        end else if (xfer) begin
            rf_we    <= (sel_addr != '0);
            rf_addr  <= sel_addr;
            rf_wdata <= sel_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

`ifndef REGFILE_ARB_FIXED_PRIO_EN
    // Pointer moves past the last winner, even for dropped x0 writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= '0;
        else if (xfer)
            rr_ptr <= (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    end
`endif

    // Saturating contention counter, active only in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            contention_cnt <= '0;
        else if (init_done && multi && contention_cnt != '1)
            contention_cnt <= contention_cnt + 1'b1;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter.
// Second instance with CNT_W=4 exercises counter saturation.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [9:0]  req_addr;
    logic [63:0] req_data;

    logic [1:0]  req_ready;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic        init_done;
    logic [15:0] contention_cnt;

    logic [1:0]  req_ready_s;
    logic        rf_we_s;
    logic [4:0]  rf_addr_s;
    logic [31:0] rf_wdata_s;
    logic        init_done_s;
    logic [3:0]  contention_cnt_s;

    int tests;
    int fails;

    regfile_wb_arbiter #(.NUM_REQ(2), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .rf_we          (rf_we),
        .rf_addr        (rf_addr),
        .rf_wdata       (rf_wdata),
        .init_done      (init_done),
        .contention_cnt (contention_cnt)
    );

    regfile_wb_arbiter #(.NUM_REQ(2), .CNT_W(4)) dut_s (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready_s),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .rf_we          (rf_we_s),
        .rf_addr        (rf_addr_s),
        .rf_wdata       (rf_wdata_s),
        .init_done      (init_done_s),
        .contention_cnt (contention_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 2'b11;
        req_addr = '0;
        req_data = '0;
        repeat (3) tick();
        tests++;
        if (rf_we !== 1'b0 || rf_addr !== 5'd0 || rf_wdata !== 32'd0) begin
            fails++;
            $display("FAIL reset_rf got we=%b a=%0d d=%h exp 0/0/0", rf_we, rf_addr, rf_wdata);
        end
        tests++;
        if (init_done !== 1'b0 || contention_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_state got done=%b cnt=%0d exp 0/0", init_done, contention_cnt);
        end
        tests++;
        if (req_ready !== 2'b00) begin
            fails++;
            $display("FAIL reset_ready got %b exp 00", req_ready);
        end
        rst = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            tick();
            tests++;
            if (rf_we !== 1'b1 || rf_addr !== 5'(k) || rf_wdata !== 32'd0) begin
                fails++;
                $display("FAIL clear_write k=%0d got we=%b a=%0d d=%h exp 1/%0d/0",
                         k, rf_we, rf_addr, rf_wdata, k);
            end
            tests++;
            if (init_done !== (k == 31)) begin
                fails++;
                $display("FAIL clear_done k=%0d got %b exp %b", k, init_done, k == 31);
            end
            if (k < 31) begin
                tests++;
                if (req_ready !== 2'b00) begin
                    fails++;
                    $display("FAIL clear_ready k=%0d got %b exp 00", k, req_ready);
                end
            end
            if (k == 20) req_valid = 2'b00;
        end
        tick();
        tests++;
        if (rf_we !== 1'b0 || init_done !== 1'b1 || contention_cnt !== 16'd0) begin
            fails++;
            $display("FAIL clear_end got we=%b done=%b cnt=%0d exp 0/1/0",
                     rf_we, init_done, contention_cnt);
        end
    endtask

    task automatic test_single;
        req_valid = 2'b01;
        req_addr[4:0] = 5'd5;
        req_data[31:0] = 32'hDEADBEEF;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin
            fails++;
            $display("FAIL single_ready got %b exp 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        tests++;
        if (rf_we !== 1'b1 || rf_addr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL single_write got we=%b a=%0d d=%h exp 1/5/deadbeef",
                     rf_we, rf_addr, rf_wdata);
        end
        tick();
        tests++;
        if (rf_we !== 1'b0 || rf_addr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL single_idle got we=%b a=%0d d=%h exp 0/5/deadbeef",
                     rf_we, rf_addr, rf_wdata);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] eg;
        logic [4:0] ea;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (31) tick();
        req_valid = 2'b11;
        req_addr = {5'd9, 5'd7};
        req_data = {32'hB1B1B1B1, 32'hA0A0A0A0};
        for (int c = 0; c < 4; c++) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
            eg = 2'b01;
`else
            eg = (c % 2 == 0) ? 2'b01 : 2'b10;
`endif
            ea = (eg == 2'b01) ? 5'd7 : 5'd9;
            #1;
            tests++;
            if (req_ready !== eg) begin
                fails++;
                $display("FAIL rr_grant c=%0d got %b exp %b", c, req_ready, eg);
            end
            tick();
            tests++;
            if (rf_we !== 1'b1 || rf_addr !== ea) begin
                fails++;
                $display("FAIL rr_write c=%0d got we=%b a=%0d exp 1/%0d", c, rf_we, rf_addr, ea);
            end
        end
        req_valid = 2'b00;
        tests++;
        if (contention_cnt !== 16'd4) begin
            fails++;
            $display("FAIL rr_count got %0d exp 4", contention_cnt);
        end
    endtask

    task automatic test_x0_drop;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b10;
        req_addr[9:5] = 5'd0;
        req_data[63:32] = 32'h1;
        #1;
        tests++;
        if (req_ready !== 2'b10) begin
            fails++;
            $display("FAIL x0_ready got %b exp 10", req_ready);
        end
        tick();
        tests++;
        if (rf_we !== 1'b0) begin
            fails++;
            $display("FAIL x0_we got %b exp 0", rf_we);
        end
        req_valid = 2'b11;
        req_addr[9:5] = 5'd9;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin
            fails++;
            $display("FAIL x0_next_grant got %b exp 01", req_ready);
        end
        tick();
        tests++;
        if (rf_we !== 1'b1 || rf_addr !== 5'd7) begin
            fails++;
            $display("FAIL x0_next_write got we=%b a=%0d exp 1/7", rf_we, rf_addr);
        end
        tests++;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        if (req_ready !== 2'b01) begin
            fails++;
            $display("FAIL x0_after_grant got %b exp 01", req_ready);
        end
`else
        if (req_ready !== 2'b10) begin
            fails++;
            $display("FAIL x0_after_grant got %b exp 10", req_ready);
        end
`endif
        tick();
        req_valid = 2'b00;
    endtask

    task automatic test_mid_reset;
        req_valid = 2'b01;
        req_addr[4:0] = 5'd3;
        req_data[31:0] = 32'h33;
        tick();
        req_valid = 2'b00;
        tests++;
        if (rf_we !== 1'b1 || contention_cnt !== 16'd6) begin
            fails++;
            $display("FAIL mid_pre got we=%b cnt=%0d exp 1/6", rf_we, contention_cnt);
        end
        #2;
        rst = 1'b1;
        req_valid = 2'b11;
        #1;
        tests++;
        if (rf_we !== 1'b0 || init_done !== 1'b0 || contention_cnt !== 16'd0) begin
            fails++;
            $display("FAIL mid_async got we=%b done=%b cnt=%0d exp 0/0/0",
                     rf_we, init_done, contention_cnt);
        end
        tests++;
        if (req_ready !== 2'b00) begin
            fails++;
            $display("FAIL mid_ready got %b exp 00", req_ready);
        end
        tick();
        rst = 1'b0;
        req_valid = 2'b00;
        for (int k = 1; k <= 31; k++) begin
            tick();
            tests++;
            if (rf_we !== 1'b1 || rf_addr !== 5'(k) || rf_wdata !== 32'd0) begin
                fails++;
                $display("FAIL mid_clear k=%0d got we=%b a=%0d d=%h exp 1/%0d/0",
                         k, rf_we, rf_addr, rf_wdata, k);
            end
        end
        tick();
        tests++;
        if (rf_we !== 1'b0 || init_done !== 1'b1) begin
            fails++;
            $display("FAIL mid_end got we=%b done=%b exp 0/1", rf_we, init_done);
        end
    endtask

    task automatic test_saturation;
        req_valid = 2'b11;
        repeat (14) tick();
        tests++;
        if (contention_cnt_s !== 4'd14) begin
            fails++;
            $display("FAIL sat_pre got %0d exp 14", contention_cnt_s);
        end
        repeat (6) tick();
        req_valid = 2'b00;
        tests++;
        if (contention_cnt_s !== 4'd15) begin
            fails++;
            $display("FAIL sat_hold got %0d exp 15", contention_cnt_s);
        end
        tests++;
        if (contention_cnt !== 16'd20) begin
            fails++;
            $display("FAIL sat_wide got %0d exp 20", contention_cnt);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        req_valid = '0;
        req_addr = '0;
        req_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_x0_drop();
        test_mid_reset();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Sequencer and write-port arbiter for the 32x32 register file, which has one write port (WE3/A3/WD3).
- After reset it runs a clear sequence that writes zero to x1..x31.
- After that it shares the single write port between NUM_REQ writeback sources (ALU, load unit, ...) using round-robin valid/ready handshakes.
- It sits between the writeback stage and the register file; its rf_* outputs drive WE3/A3/WD3 directly.

Parameters:
- NUM_REQ, 2, number of writeback requesters (2..4).
- CNT_W, 16, width of the saturating contention counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_ready  output  NUM_REQ  per-requester grant; a transfer happens when valid&ready.
- req_addr  input  NUM_REQ*5  destination register; requester i uses bits [5i+4:5i].
- req_data  input  NUM_REQ*32  write data; requester i uses bits [32i+31:32i].
- rf_we  output  1  register-file write enable (to WE3).
- rf_addr  output  5  register-file write address (to A3).
- rf_wdata  output  32  register-file write data (to WD3).
- init_done  output  1  high once the clear sequence has completed.
- contention_cnt  output  CNT_W  saturating count of cycles in RUN with more than one req_valid high.

Behaviour:
- Reset (asynchronous, any time, including mid-clear or mid-run):
  - state=CLEAR, clr_cnt=1, rr_ptr=0.
  - rf_we=0, rf_addr=0, rf_wdata=0, contention_cnt=0, init_done=0.
  - req_ready=0 combinationally while rst is high.
- FSM states are CLEAR and RUN.
- CLEAR:
  - req_ready=0 for all requesters.
  - Each rising edge registers rf_we=1, rf_addr=clr_cnt, rf_wdata=0, then clr_cnt++.
  - On the edge where clr_cnt==31, state moves to RUN.
  - Result: exactly 31 consecutive write cycles, addresses 1..31, starting with the first edge after rst falls.
- RUN:
  - init_done=1, driven as state==RUN.
  - The grant is combinational from req_valid and rr_ptr only; it never depends on req_ready, so there is no combinational loop.
  - The winner is the first valid index at or after rr_ptr, searching modulo NUM_REQ.
  - req_ready is one-hot on the winner, and all zero when no request is valid.
  - At most one transfer per cycle; the register file never back-pressures.
  - On a transfer from requester i, the next edge registers:
    - rf_addr=req_addr[i], rf_wdata=req_data[i];
    - rf_we=1 only if req_addr[i]!=0 (x0 writes are accepted and dropped);
    - rr_ptr=(i+1) mod NUM_REQ.
  - With no transfer, the next edge registers rf_we=0; rf_addr and rf_wdata hold their values; rr_ptr holds.
  - Latency from handshake to rf_we high is 1 cycle.
- Losing requesters keep req_valid and hold their addr/data stable until granted; this is a requester obligation.
- contention_cnt increments on edges in RUN when popcount(req_valid)>=2. It saturates at all-ones and clears only on reset.
- The last clear write (x31) is visible on rf_* in the first RUN cycle. A request granted in that cycle appears on rf_* one cycle later, so there is no overlap.

Optional Feature:
- Macro: REGFILE_ARB_FIXED_PRIO_EN.
- When defined:
  - the winner is the lowest-index valid requester (fixed priority);
  - rr_ptr logic is removed;
  - contention_cnt still counts.
- When undefined: round-robin arbitration as described above.

Decomposition:
- Shared package regfile_pkg holds:
  - REG_ADDR_W=5, XLEN=32, NUM_REGS=32;
  - state encoding ST_CLEAR=1'b0, ST_RUN=1'b1.
- Sub-module rr_arbiter: combinational round-robin grant from (valid, ptr) producing a one-hot grant and a grant index.
  - The fixed-priority variant lives inside rr_arbiter under the macro.
  - The top block owns the FSM, the output registers and the counter.

Test Plan:
- Clear sequence:
  - Stimulus: rst high for 3 cycles then release, all req_valid=0.
  - Response: rf_we=1 for 31 cycles with rf_addr 1,2,...,31 and rf_wdata=0, then rf_we=0 and init_done=1. req_ready stays 0 throughout CLEAR even with req_valid=2'b11.
- Single request:
  - Stimulus: in RUN, req_valid=01, req_addr[0]=5, req_data[0]=32'hDEADBEEF.
  - Response: req_ready=01 the same cycle; next cycle rf_we=1, rf_addr=5, rf_wdata=32'hDEADBEEF.
- Round-robin contention:
  - Stimulus: req_valid=11 held for 4 cycles, addresses 7 and 9.
  - Response: grants alternate 01,10,01,10; rf_addr sequence 7,9,7,9; contention_cnt=4.
  - With REGFILE_ARB_FIXED_PRIO_EN defined, requester 0 wins all 4 cycles.
- x0 drop:
  - Stimulus: req_valid=10, req_addr[1]=0, data=32'h1.
  - Response: req_ready=10; next cycle rf_we=0; rr_ptr still advances, so a following 11 request grants requester 0.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously between clock edges during RUN with rf_we=1.
  - Response: rf_we=0, init_done=0, contention_cnt=0 immediately; after release the full 31-cycle clear repeats.
- Saturation:
  - Stimulus: CNT_W=4, req_valid=11 for 20 cycles.
  - Response: contention_cnt stops at 15.
